// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for the N/S/E/W light buses: latches a fault on bad codes,
// cross-axis conflicts, illegal sequences, short dwell or a stalled controller, and requests lamp flash.
module traffic_conflict_monitor #(
   parameter int unsigned MIN_GREEN  = 4,
   parameter int unsigned MIN_YELLOW = 2,
   parameter int unsigned MAX_STALE  = 64,
   parameter int unsigned FLASH_DIV  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] north_both,
   input  logic [1:0] south_both,
   input  logic [1:0] east_both,
   input  logic [1:0] west_both,
   input  logic       clr,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_dir,
   output logic       flash
);

   localparam int unsigned NUM_APP = 4;
   localparam int unsigned LIGHT_W = 2;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned DIR_W   = 2;

   localparam logic [LIGHT_W-1:0] L_RED     = 2'b00;
   localparam logic [LIGHT_W-1:0] L_YELLOW  = 2'b01;
   localparam logic [LIGHT_W-1:0] L_GREEN   = 2'b10;
   localparam logic [LIGHT_W-1:0] L_INVALID = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] STALE_LAST   = CNT_W'(MAX_STALE - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_DIV - 1);

   localparam logic [CODE_W-1:0] C_NONE     = 3'd0;
   localparam logic [CODE_W-1:0] C_INVALID  = 3'd1;
   localparam logic [CODE_W-1:0] C_CONFLICT = 3'd2;
   localparam logic [CODE_W-1:0] C_TRANS    = 3'd3;
   localparam logic [CODE_W-1:0] C_SHORT_G  = 3'd4;
   localparam logic [CODE_W-1:0] C_SHORT_Y  = 3'd5;
   localparam logic [CODE_W-1:0] C_STALL    = 3'd6;

   typedef enum logic {
      S_MONITOR = 1'b0,
      S_FAULT   = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic [NUM_APP-1:0][LIGHT_W-1:0] cur;
   logic [NUM_APP-1:0][LIGHT_W-1:0] prev_q, prev_d;
   logic [NUM_APP-1:0][CNT_W-1:0]   dwell_q, dwell_d;
   logic [CNT_W-1:0]                stale_q, stale_d;
   logic [CNT_W-1:0]                flash_cnt_q, flash_cnt_d;
   logic                            flash_q, flash_d;
   logic [CODE_W-1:0]               code_q, code_d;
   logic [DIR_W-1:0]                dir_q, dir_d;

   logic [NUM_APP-1:0] changed;
   logic [NUM_APP-1:0] v_inv;
   logic [NUM_APP-1:0] v_trans;
   logic [NUM_APP-1:0] v_short_g;
   logic [NUM_APP-1:0] v_short_y;
   logic               conflict;
   logic [DIR_W-1:0]   conflict_dir;
   logic               stall;
   logic               viol;
   logic [CODE_W-1:0]  viol_code;
   logic [DIR_W-1:0]   viol_dir;
   logic               clear_ok;

   assign cur = {west_both, east_both, south_both, north_both};

   function automatic logic [DIR_W-1:0] first_idx(input logic [NUM_APP-1:0] v);
      first_idx = '0;
      for (int i = NUM_APP - 1; i >= 0; i--) begin
         if (v[i]) first_idx = DIR_W'(i);
      end
   endfunction

   // Per-approach violation detection against the previous sample and dwell count
   always_comb begin
      changed   = '0;
      v_inv     = '0;
      v_trans   = '0;
      v_short_g = '0;
      v_short_y = '0;
      for (int i = 0; i < NUM_APP; i++) begin
         changed[i]   = (cur[i] != prev_q[i]);
         v_inv[i]     = (cur[i] == L_INVALID);
         v_trans[i]   = changed[i] &&
                        !((prev_q[i] == L_RED    && cur[i] == L_GREEN)  ||
                          (prev_q[i] == L_GREEN  && cur[i] == L_YELLOW) ||
                          (prev_q[i] == L_YELLOW && cur[i] == L_RED));
         v_short_g[i] = changed[i] && (prev_q[i] == L_GREEN)  && (dwell_q[i] < MIN_GREEN_C);
         v_short_y[i] = changed[i] && (prev_q[i] == L_YELLOW) && (dwell_q[i] < MIN_YELLOW_C);
      end
      conflict     = ((cur[0] != L_RED) || (cur[1] != L_RED)) &&
                     ((cur[2] != L_RED) || (cur[3] != L_RED));
      conflict_dir = (cur[0] != L_RED) ? 2'd0 : 2'd1;
      stall        = !(|changed) && (stale_q >= STALE_LAST);
      clear_ok     = clr && !(|v_inv) && !conflict;
   end

   // Lowest code wins, then lowest approach index within that code
   always_comb begin
      viol      = 1'b1;
      viol_code = C_NONE;
      viol_dir  = '0;
      if (|v_inv) begin
         viol_code = C_INVALID;
         viol_dir  = first_idx(v_inv);
      end else if (conflict) begin
         viol_code = C_CONFLICT;
         viol_dir  = conflict_dir;
      end else if (|v_trans) begin
         viol_code = C_TRANS;
         viol_dir  = first_idx(v_trans);
      end else if (|v_short_g) begin
         viol_code = C_SHORT_G;
         viol_dir  = first_idx(v_short_g);
      end else if (|v_short_y) begin
         viol_code = C_SHORT_Y;
         viol_dir  = first_idx(v_short_y);
      end else if (stall) begin
         viol_code = C_STALL;
      end else begin
         viol = 1'b0;
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d     = state_q;
      prev_d      = cur;
      dwell_d     = dwell_q;
      stale_d     = (|changed) ? '0 : ((stale_q == CNT_MAX) ? CNT_MAX : stale_q + 8'd1);
      flash_d     = flash_q;
      flash_cnt_d = flash_cnt_q;
      code_d      = code_q;
      dir_d       = dir_q;
      for (int i = 0; i < NUM_APP; i++) begin
         if (changed[i]) dwell_d[i] = 8'd1;
         else if (dwell_q[i] != CNT_MAX) dwell_d[i] = dwell_q[i] + 8'd1;
      end
      case (state_q)
         S_MONITOR: begin
            if (viol) begin
               state_d     = S_FAULT;
               code_d      = viol_code;
               dir_d       = viol_dir;
               flash_d     = 1'b1;
               flash_cnt_d = '0;
            end
         end
         S_FAULT: begin
            if (clear_ok) begin
               // Saturated dwell lets the first post-clear transition through
               state_d     = S_MONITOR;
               code_d      = C_NONE;
               dir_d       = '0;
               flash_d     = 1'b0;
               flash_cnt_d = '0;
               stale_d     = '0;
               dwell_d     = '1;
            end else if (flash_cnt_q >= FLASH_LAST) begin
               flash_d     = !flash_q;
               flash_cnt_d = '0;
            end else begin
               flash_cnt_d = flash_cnt_q + 8'd1;
            end
         end
         default: state_d = S_MONITOR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_MONITOR;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q      <= '0;
         dwell_q     <= '0;
         stale_q     <= '0;
         flash_q     <= 1'b0;
         flash_cnt_q <= '0;
         code_q      <= C_NONE;
         dir_q       <= '0;
      end else begin
         prev_q      <= prev_d;
         dwell_q     <= dwell_d;
         stale_q     <= stale_d;
         flash_q     <= flash_d;
         flash_cnt_q <= flash_cnt_d;
         code_q      <= code_d;
         dir_q       <= dir_d;
      end
   end

   assign fault      = (state_q == S_FAULT);
   assign fault_code = code_q;
   assign fault_dir  = dir_q;
   assign flash      = flash_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: legal phasing, each fault cause,
// priority, stall/flash timing, clear gating and asynchronous reset.
module tb_traffic_conflict_monitor;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] G = 2'b10;
   localparam logic [1:0] X = 2'b11;

   logic       clk;
   logic       rst;
   logic [1:0] north_both, south_both, east_both, west_both;
   logic       clr;
   logic       fault;
   logic [2:0] fault_code;
   logic [1:0] fault_dir;
   logic       flash;

   int n_vec  = 0;
   int n_miss = 0;

   traffic_conflict_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .north_both (north_both),
      .south_both (south_both),
      .east_both  (east_both),
      .west_both  (west_both),
      .clr        (clr),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_dir  (fault_dir),
      .flash      (flash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic f, input logic [2:0] code,
                          input logic [1:0] dir, input logic fl);
      chk({tag, "_fault"}, 32'(fault), 32'(f));
      chk({tag, "_code"},  32'(fault_code), 32'(code));
      chk({tag, "_dir"},   32'(fault_dir), 32'(dir));
      chk({tag, "_flash"}, 32'(flash), 32'(fl));
   endtask

   // Drive one set of codes, then sample 1 time unit after the capturing edge
   task automatic step(input logic [1:0] n, input logic [1:0] s, input logic [1:0] e, input logic [1:0] w);
      north_both = n;
      south_both = s;
      east_both  = e;
      west_both  = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      north_both = R;
      south_both = R;
      east_both  = R;
      west_both  = R;
      clr        = 1'b0;
      rst        = 1'b0;
      #2;
      rst        = 1'b1;
   endtask

   initial begin
      rst        = 1'b0;
      clr        = 1'b0;
      north_both = R;
      south_both = R;
      east_both  = R;
      west_both  = R;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 3'd0, 2'd0, 1'b0);
      rst = 1'b1;

      // Legal four-phase cycle, repeated
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 5; k++) begin
            step(G, G, R, R);
            chk("legal_ns_g_fault", 32'(fault), 0);
         end
         for (int k = 0; k < 2; k++) begin
            step(Y, Y, R, R);
            chk("legal_ns_y_fault", 32'(fault), 0);
         end
         step(R, R, R, R);
         for (int k = 0; k < 5; k++) begin
            step(R, R, G, G);
            chk("legal_ew_g_fault", 32'(fault), 0);
            chk("legal_ew_g_flash", 32'(flash), 0);
         end
         for (int k = 0; k < 2; k++) begin
            step(R, R, Y, Y);
            chk("legal_ew_y_fault", 32'(fault), 0);
         end
         step(R, R, R, R);
         chk("legal_red_flash", 32'(flash), 0);
      end

      // Conflict, clear refused while conflict persists, then clean clear
      do_reset();
      step(G, R, R, R);
      chk_out("conf_pre", 1'b0, 3'd0, 2'd0, 1'b0);
      step(G, R, G, R);
      chk_out("conflict", 1'b1, 3'd2, 2'd0, 1'b1);
      clr = 1'b1;
      step(G, R, G, R);
      chk_out("clr_blocked", 1'b1, 3'd2, 2'd0, 1'b1);
      step(G, R, R, R);
      clr = 1'b0;
      chk_out("clr_ok", 1'b0, 3'd0, 2'd0, 1'b0);
      step(Y, R, R, R);
      chk_out("post_clr_gy", 1'b0, 3'd0, 2'd0, 1'b0);

      // S green -> red
      do_reset();
      step(R, G, R, R);
      step(R, R, R, R);
      chk_out("illegal_s", 1'b1, 3'd3, 2'd1, 1'b1);

      // W green only 2 cycles
      do_reset();
      step(R, R, R, G);
      step(R, R, R, G);
      chk("short_g_pre", 32'(fault), 0);
      step(R, R, R, Y);
      chk_out("short_green_w", 1'b1, 3'd4, 2'd3, 1'b1);

      // E yellow only 1 cycle
      do_reset();
      for (int k = 0; k < 4; k++) step(R, R, G, R);
      step(R, R, Y, R);
      chk("short_y_pre", 32'(fault), 0);
      step(R, R, R, R);
      chk_out("short_yellow_e", 1'b1, 3'd5, 2'd2, 1'b1);

      // Invalid beats conflict and illegal transition
      do_reset();
      step(X, R, R, G);
      chk_out("priority", 1'b1, 3'd1, 2'd0, 1'b1);

      // Stall after 64 unchanged edges, then flash cadence
      do_reset();
      for (int k = 0; k < 63; k++) step(R, R, R, R);
      chk_out("stall_pre", 1'b0, 3'd0, 2'd0, 1'b0);
      step(R, R, R, R);
      chk_out("stall", 1'b1, 3'd6, 2'd0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         step(R, R, R, R);
         chk("flash_hi", 32'(flash), 1);
      end
      for (int k = 0; k < 8; k++) begin
         step(R, R, R, R);
         chk("flash_lo", 32'(flash), 0);
      end
      step(R, R, R, R);
      chk("flash_hi2", 32'(flash), 1);
      chk("stall_code_hold", 32'(fault_code), 6);

      // Asynchronous reset while faulted, sampled between edges
      #1;
      rst = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 3'd0, 2'd0, 1'b0);
      rst = 1'b1;
      step(R, R, R, R);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
